// File: rtl/sample_iterator_if.sv
// Bundles the sample iterator's bus signals: the triangle/bbox handshake from
// the bbox stage, the halt/MSAA controls, and the sample stream to the sample test.
interface sample_iterator_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
);
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
    logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
    logic                                   validTri_R13H;
    logic [3:0]                             subSample_RnnnnU;
    logic                                   halt_RnnnnH;
    logic                                   stall_R13H;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
    logic [1:0][SIGFIG-1:0]                 sample_R14S;
    logic                                   validSamp_R14H;

    modport slave (
        input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, halt_RnnnnH,
        output stall_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );

    modport master (
        output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, halt_RnnnnH,
        input  stall_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );
endinterface

// File: rtl/sample_iterator.sv
// Walks one triangle's bounding box in raster order, emitting one sample
// location per cycle alongside the latched triangle and color.
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input logic               clk,
    input logic               rst,
    sample_iterator_if.slave  bus
);
    typedef enum logic {WAIT, TEST} state_t;

    state_t                                 state_q, state_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
    logic [1:0][SIGFIG-1:0]                 ll_q, ll_d;
    logic [1:0][SIGFIG-1:0]                 ur_q, ur_d;
    logic [SIGFIG-1:0]                      step_q, step_d;
    logic [1:0][SIGFIG-1:0]                 sample_q, sample_d;
    logic                                   valid_q, valid_d;

    logic [SIGFIG-1:0]   stepIn;
    logic signed [SIGFIG:0] nextX, nextY, urX, urY;
    logic                boxInverted;

    // One extra adder bit keeps x+step from wrapping past the signed range.
    assign nextX = $signed({sample_q[0][SIGFIG-1], sample_q[0]}) + $signed({1'b0, step_q});
    assign nextY = $signed({sample_q[1][SIGFIG-1], sample_q[1]}) + $signed({1'b0, step_q});
    assign urX   = $signed({ur_q[0][SIGFIG-1], ur_q[0]});
    assign urY   = $signed({ur_q[1][SIGFIG-1], ur_q[1]});

    assign boxInverted = ($signed(bus.box_R13S[1][0]) < $signed(bus.box_R13S[0][0])) ||
                         ($signed(bus.box_R13S[1][1]) < $signed(bus.box_R13S[0][1]));

    always_comb begin
        case (bus.subSample_RnnnnU)
            4'b0100: stepIn = SIGFIG'(1) << (RADIX - 1);
            4'b0010: stepIn = SIGFIG'(1) << (RADIX - 2);
            4'b0001: stepIn = SIGFIG'(1) << (RADIX - 3);
            default: stepIn = SIGFIG'(1) << RADIX;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        tri_d    = tri_q;
        color_d  = color_q;
        ll_d     = ll_q;
        ur_d     = ur_q;
        step_d   = step_q;
        sample_d = sample_q;
        valid_d  = valid_q;

        if (!bus.halt_RnnnnH) begin
            case (state_q)
                WAIT: begin
                    valid_d = 1'b0;
                    // An inverted box has no samples, so it is consumed without leaving WAIT.
                    if (bus.validTri_R13H && !boxInverted) begin
                        tri_d    = bus.tri_R13S;
                        color_d  = bus.color_R13U;
                        ll_d     = bus.box_R13S[0];
                        ur_d     = bus.box_R13S[1];
                        step_d   = stepIn;
                        sample_d = bus.box_R13S[0];
                        valid_d  = 1'b1;
                        state_d  = TEST;
                    end
                end
                TEST: begin
                    if (nextX <= urX) begin
                        sample_d[0] = nextX[SIGFIG-1:0];
                    end else if (nextY <= urY) begin
                        sample_d[0] = ll_q[0];
                        sample_d[1] = nextY[SIGFIG-1:0];
                    end else begin
                        valid_d = 1'b0;
                        state_d = WAIT;
                    end
                end
                default: state_d = WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= WAIT;
            tri_q    <= '0;
            color_q  <= '0;
            ll_q     <= '0;
            ur_q     <= '0;
            step_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tri_q    <= tri_d;
            color_q  <= color_d;
            ll_q     <= ll_d;
            ur_q     <= ur_d;
            step_q   <= step_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.stall_R13H     = (state_q == TEST);
    assign bus.tri_R14S       = tri_q;
    assign bus.color_R14U     = color_q;
    assign bus.sample_R14S    = sample_q;
    assign bus.validSamp_R14H = valid_q;
endmodule
